// File: rtl/matrix_enc_pkg.sv
// -----------------------------------------------------------------------------
// matrix_enc_pkg
// Shared constants and the scheduler state type for the matrix encoder.
//   LINES     lines per matrix (one per slice)
//   ADDR_W    line address width
//   DATA_W    bits per line (one 5x5 plane)
//   N_STAGES  stage engines sequenced per round
//   ROUNDS    rounds per encode
//   TIMEOUT   cycles an enabled stage may run before the watchdog aborts
//   ROUND_W   width of the round index output
// -----------------------------------------------------------------------------
package matrix_enc_pkg;

    localparam int unsigned LINES    = 64;
    localparam int unsigned ADDR_W   = $clog2(LINES);
    localparam int unsigned DATA_W   = 25;
    localparam int unsigned N_STAGES = 5;
    localparam int unsigned ROUNDS   = 24;
    localparam int unsigned TIMEOUT  = 4095;
    localparam int unsigned ROUND_W  = 5;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SWAP,
        DONE
    } state_t;

endpackage

// File: rtl/sched_watchdog.sv
// -----------------------------------------------------------------------------
// sched_watchdog
// Counts cycles while a stage is enabled and flags expiry so the scheduler can
// abandon a stage that never reports completion.
//   clk     clock, rising edge
//   rst     asynchronous, active-low reset
//   clr     synchronous clear of the count (issued while a stage is cleared)
//   en      count enable (stage running)
//   expire  high during the TIMEOUT-th consecutive enabled cycle
// -----------------------------------------------------------------------------
module sched_watchdog #(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expire) begin
            count <= count + CW'(1);
        end
    end

    // Count holds the number of enabled cycles already elapsed, so matching
    // TIMEOUT-1 marks the final permitted cycle: the enable is seen for
    // exactly TIMEOUT cycles before the scheduler leaves the stage.
    assign expire = en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/encoder_stage_scheduler.sv
// -----------------------------------------------------------------------------
// encoder_stage_scheduler
// Sequences the stage engines of the matrix encoder over a shared ping-pong
// line memory: ROUNDS rounds of N_STAGES stages, each stage receiving a clear
// pulse followed by a held enable. The active stage's read address and write
// port are muxed onto the memory; the write address is generated here.
//   clk, rst          clock / asynchronous active-low reset
//   start, abort      host request (IDLE only) / host abort (any state)
//   busy, done, err   not-IDLE / end-of-encode pulse / sticky fault
//   round_idx         current round
//   bank_sel          read bank; writes target the other bank
//   stage_clr/en      one-hot clear pulse / held enable to the active stage
//   stage_done        completion pulses from the stages
//   stage_cnt         packed per-stage read addresses
//   stage_wr_en/val   per-stage write strobes / packed write data
//   mem_rd_addr       active stage read address
//   mem_wr_en/addr    gated write strobe / sequential write pointer
//   mem_wr_data       active stage write data
// -----------------------------------------------------------------------------
module encoder_stage_scheduler
    import matrix_enc_pkg::*;
#(
    parameter int unsigned LINES    = matrix_enc_pkg::LINES,
    parameter int unsigned DATA_W   = matrix_enc_pkg::DATA_W,
    parameter int unsigned N_STAGES = matrix_enc_pkg::N_STAGES,
    parameter int unsigned ROUNDS   = matrix_enc_pkg::ROUNDS,
    parameter int unsigned TIMEOUT  = matrix_enc_pkg::TIMEOUT,
    parameter int unsigned ADDR_W   = $clog2(LINES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [ROUND_W-1:0]           round_idx,
    output logic                         bank_sel,
    output logic [N_STAGES-1:0]          stage_clr,
    output logic [N_STAGES-1:0]          stage_en,
    input  logic [N_STAGES-1:0]          stage_done,
    input  logic [N_STAGES*ADDR_W-1:0]   stage_cnt,
    input  logic [N_STAGES-1:0]          stage_wr_en,
    input  logic [N_STAGES*DATA_W-1:0]   stage_wr_val,
    output logic [ADDR_W-1:0]            mem_rd_addr,
    output logic                         mem_wr_en,
    output logic [ADDR_W-1:0]            mem_wr_addr,
    output logic [DATA_W-1:0]            mem_wr_data
);

    localparam int unsigned     SW   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(LINES);

    state_t               state_q, state_d;
    logic [SW-1:0]        stage_q, stage_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic                 bank_q, bank_d;
    logic                 err_q, err_d;
    logic [ADDR_W:0]      wr_ptr_q, wr_ptr_d;
    logic                 act_done, act_wr;
    logic                 wd_expire;

    sched_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == CLEAR),
        .en     (state_q == RUN),
        .expire (wd_expire)
    );

    // Everything from the stages is taken only from the active index.
    always_comb begin
        act_done    = 1'b0;
        act_wr      = 1'b0;
        mem_rd_addr = '0;
        mem_wr_data = '0;
        stage_clr   = '0;
        stage_en    = '0;
        for (int unsigned i = 0; i < N_STAGES; i++) begin
            if (stage_q == SW'(i)) begin
                act_done     = stage_done[i];
                act_wr       = stage_wr_en[i];
                mem_rd_addr  = stage_cnt[i*ADDR_W +: ADDR_W];
                mem_wr_data  = stage_wr_val[i*DATA_W +: DATA_W];
                stage_clr[i] = (state_q == CLEAR);
                stage_en[i]  = (state_q == RUN);
            end
        end
    end

    assign mem_wr_en   = (state_q == RUN) && act_wr && (wr_ptr_q < FULL);
    assign mem_wr_addr = wr_ptr_q[ADDR_W-1:0];
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign err         = err_q;
    assign round_idx   = round_q;
    assign bank_sel    = bank_q;

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        round_d  = round_q;
        bank_d   = bank_q;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;

        if (mem_wr_en) begin
            wr_ptr_d = wr_ptr_q + (ADDR_W + 1)'(1);
        end

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_d   = 1'b0;
                        round_d = '0;
                        stage_d = '0;
                        bank_d  = 1'b0;
                        state_d = CLEAR;
                    end
                end
                CLEAR: begin
                    wr_ptr_d = '0;
                    state_d  = RUN;
                end
                RUN: begin
                    // A strobe with the pointer already at LINES is dropped.
                    if (act_wr && (wr_ptr_q == FULL)) begin
                        err_d = 1'b1;
                    end
                    if (wd_expire) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (act_done) begin
                        if (wr_ptr_q != FULL) begin
                            err_d = 1'b1;
                        end
                        state_d = SWAP;
                    end
                end
                SWAP: begin
                    bank_d = ~bank_q;
                    if (stage_q == SW'(N_STAGES - 1)) begin
                        stage_d = '0;
                        if (round_q == ROUND_W'(ROUNDS - 1)) begin
                            state_d = DONE;
                        end else begin
                            round_d = round_q + ROUND_W'(1);
                            state_d = CLEAR;
                        end
                    end else begin
                        stage_d = stage_q + SW'(1);
                        state_d = CLEAR;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            round_q  <= '0;
            bank_q   <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            round_q  <= round_d;
            bank_q   <= bank_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

endmodule

// File: tb/tb_encoder_stage_scheduler.sv
// -----------------------------------------------------------------------------
// tb_encoder_stage_scheduler
// Stub stage engines feed the scheduler; expected memory writes and stage
// activations are queued as stimulus is issued and checked by a monitor.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_encoder_stage_scheduler;

    localparam int unsigned LINES   = 64;
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned DATA_W  = 25;
    localparam int unsigned N_ST    = 5;
    localparam int unsigned ROUNDS  = 2;
    localparam int unsigned TIMEOUT = 100;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic                    abort = 1'b0;
    logic                    busy, done, err, bank_sel, mem_wr_en;
    logic [4:0]              round_idx;
    logic [N_ST-1:0]         stage_clr, stage_en;
    logic [N_ST-1:0]         stage_done = '0;
    logic [N_ST*ADDR_W-1:0]  stage_cnt = '0;
    logic [N_ST-1:0]         stage_wr_en = '0;
    logic [N_ST*DATA_W-1:0]  stage_wr_val = '0;
    logic [ADDR_W-1:0]       mem_rd_addr, mem_wr_addr;
    logic [DATA_W-1:0]       mem_wr_data;

    always #5 clk = ~clk;

    encoder_stage_scheduler #(
        .LINES    (LINES),
        .DATA_W   (DATA_W),
        .N_STAGES (N_ST),
        .ROUNDS   (ROUNDS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .round_idx    (round_idx),
        .bank_sel     (bank_sel),
        .stage_clr    (stage_clr),
        .stage_en     (stage_en),
        .stage_done   (stage_done),
        .stage_cnt    (stage_cnt),
        .stage_wr_en  (stage_wr_en),
        .stage_wr_val (stage_wr_val),
        .mem_rd_addr  (mem_rd_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data)
    );

    typedef struct {
        int unsigned       stage;
        int unsigned       addr;
        logic [DATA_W-1:0] data;
        int unsigned       rd;
    } wr_item_t;

    typedef struct {
        int unsigned stage;
        int unsigned round;
        int unsigned bank;
    } act_item_t;

    wr_item_t  wr_q[$];
    act_item_t act_q[$];

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- stub stage engines ----------------
    int unsigned       target[N_ST];
    bit                never_done[N_ST];
    bit                noise_en = 1'b0;
    int                abort_stage = -1;
    int unsigned       abort_fires = 0;
    int unsigned       wcount[N_ST];
    bit                done_sent[N_ST];
    int unsigned       idle_budget[N_ST];
    logic [DATA_W-1:0] stub_v;
    logic [ADDR_W-1:0] stub_rd;

    always @(posedge clk) begin
        #1;
        stage_done  = '0;
        stage_wr_en = '0;
        abort       = 1'b0;
        for (int unsigned s = 0; s < N_ST; s++) begin
            if (stage_clr[s]) begin
                wcount[s]      = 0;
                done_sent[s]   = 1'b0;
                idle_budget[s] = $urandom_range(0, 15);
            end else if (stage_en[s]) begin
                stub_rd = ADDR_W'($urandom);
                stage_cnt[s*ADDR_W +: ADDR_W] = stub_rd;
                if (wcount[s] < target[s]) begin
                    if (idle_budget[s] > 0 && $urandom_range(0, 3) == 0) begin
                        idle_budget[s]--;
                    end else begin
                        stub_v = DATA_W'($urandom);
                        stage_wr_en[s] = 1'b1;
                        stage_wr_val[s*DATA_W +: DATA_W] = stub_v;
                        if (wcount[s] < LINES) begin
                            wr_q.push_back('{s, wcount[s], stub_v, int'(stub_rd)});
                        end
                        wcount[s]++;
                    end
                end else if (!done_sent[s] && !never_done[s]) begin
                    stage_done[s] = 1'b1;
                    done_sent[s]  = 1'b1;
                    if (abort_stage == int'(s)) begin
                        abort = 1'b1;
                        abort_fires++;
                    end
                end
            end else if (noise_en) begin
                stage_cnt[s*ADDR_W +: ADDR_W]    = ADDR_W'($urandom);
                stage_wr_val[s*DATA_W +: DATA_W] = DATA_W'($urandom);
                stage_wr_en[s] = 1'($urandom_range(0, 1));
                stage_done[s]  = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // ---------------- monitor ----------------
    logic [N_ST-1:0] prev_en    = '0;
    logic            prev_bank  = 1'b0;
    logic            prev_abort = 1'b0;
    int unsigned     done_cnt   = 0;
    int unsigned     toggles    = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (mem_wr_en) begin
                chk("wr_expected", wr_q.size() != 0, 1);
                if (wr_q.size() != 0) begin
                    wr_item_t w;
                    w = wr_q.pop_front();
                    chk("wr_stage", stage_en, longint'(1) << w.stage);
                    chk("wr_addr", mem_wr_addr, w.addr);
                    chk("wr_data", mem_wr_data, w.data);
                    chk("rd_addr", mem_rd_addr, w.rd);
                end
            end
            if (stage_en != '0 && prev_en == '0) begin
                chk("act_expected", act_q.size() != 0, 1);
                if (act_q.size() != 0) begin
                    act_item_t a;
                    a = act_q.pop_front();
                    chk("act_stage", stage_en, longint'(1) << a.stage);
                    chk("act_round", round_idx, a.round);
                    chk("act_bank", bank_sel, a.bank);
                end
            end
            if (prev_abort) begin
                chk("abort_en_off", stage_en, 0);
                chk("abort_busy", busy, 0);
            end
            if (done) done_cnt++;
            if (bank_sel != prev_bank) toggles++;
        end
        prev_abort = abort;
        prev_en    = stage_en;
        prev_bank  = bank_sel;
    end

    // ---------------- sequencing helpers ----------------
    task automatic push_acts(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            act_q.push_back('{k % N_ST, k / N_ST, k % 2});
        end
    endtask

    task automatic begin_run(input string tag);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        chk({tag, "_accept_busy"}, busy, 1);
        chk({tag, "_err_cleared"}, err, 0);
        @(posedge clk); #2;
        chk({tag, "_latency_en0"}, stage_en, 1);
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n;
        n = 0;
        while (busy && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        chk({tag, "_finished"}, busy, 0);
    endtask

    task automatic full_run(input string tag, input bit exp_err, input bit mid_start);
        int unsigned d0, t0;
        d0 = done_cnt;
        t0 = toggles;
        push_acts(N_ST * ROUNDS);
        begin_run(tag);
        if (mid_start) begin
            repeat (20) @(posedge clk);
            #2 start = 1'b1;
            @(posedge clk); #2 start = 1'b0;
        end
        wait_idle(tag);
        repeat (2) @(posedge clk);
        #2;
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_bank_toggles"}, toggles - t0, N_ST * ROUNDS);
        chk({tag, "_bank_final"}, bank_sel, 0);
        chk({tag, "_wr_q_empty"}, wr_q.size(), 0);
        chk({tag, "_act_q_empty"}, act_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int unsigned d0, f0, n;
        for (int unsigned s = 0; s < N_ST; s++) begin
            target[s]     = LINES;
            never_done[s] = 1'b0;
        end

        // reset held for three cycles
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_round", round_idx, 0);
        chk("rst_bank", bank_sel, 0);
        chk("rst_clr", stage_clr, 0);
        chk("rst_en", stage_en, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_wr_addr", mem_wr_addr, 0);
        chk("rst_rd_addr", mem_rd_addr, 0);
        chk("rst_wr_data", mem_wr_data, 0);
        @(posedge clk); #2 rst = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("idle_no_start_busy", busy, 0);
        chk("idle_no_start_en", stage_en, 0);

        // clean encode
        full_run("normal", 1'b0, 1'b0);

        // stage 2 finishes one write short
        target[2] = LINES - 1;
        full_run("short_stage2", 1'b1, 1'b0);
        target[2] = LINES;

        // stage 0 issues one write too many
        target[0] = LINES + 1;
        full_run("overflow_stage0", 1'b1, 1'b0);
        target[0] = LINES;

        // noise from inactive stages plus a mid-run start pulse
        noise_en = 1'b1;
        full_run("noise", 1'b0, 1'b1);
        noise_en = 1'b0;

        // stage 1 never completes: watchdog
        never_done[1] = 1'b1;
        d0 = done_cnt;
        push_acts(2);
        begin_run("wdog");
        n = 0;
        while (!stage_en[1] && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        chk("wdog_stage1_reached", stage_en[1], 1);
        repeat (TIMEOUT - 1) @(posedge clk);
        #2;
        chk("wdog_before_busy", busy, 1);
        chk("wdog_before_err", err, 0);
        @(posedge clk); #2;
        chk("wdog_busy", busy, 0);
        chk("wdog_err", err, 1);
        chk("wdog_en", stage_en, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("wdog_no_done", done_cnt - d0, 0);
        chk("wdog_wr_q_empty", wr_q.size(), 0);
        chk("wdog_act_q_empty", act_q.size(), 0);
        never_done[1] = 1'b0;

        // abort coinciding with stage 3 completion
        abort_stage = 3;
        d0 = done_cnt;
        f0 = abort_fires;
        push_acts(4);
        begin_run("abort");
        wait_idle("abort");
        repeat (3) @(posedge clk);
        #2;
        chk("abort_fired", abort_fires - f0, 1);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_err_hold", err, 0);
        chk("abort_round_hold", round_idx, 0);
        chk("abort_wr_q_empty", wr_q.size(), 0);
        chk("abort_act_q_empty", act_q.size(), 0);
        abort_stage = -1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
